// File: rtl/ili9341_init_seq.sv
// ILI9341 power-up sequencer: hardware reset handshake, settle wait, then a fixed
// command/data table streamed byte by byte to the SPI writer.
module ili9341_init_seq #(
    parameter int POST_RST_WAIT = 12_000_000,
    parameter int DLY_CYCLES    = 12_000_000,
    parameter int RST_TIMEOUT   = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    output logic       o_reset_ena,
    output logic       o_reset_val,
    input  logic       i_reset_sent,
    output logic       o_spi_valid,
    output logic [7:0] o_spi_data,
    output logic       o_spi_dc,
    input  logic       i_spi_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error
);
    localparam int TW = $clog2(RST_TIMEOUT + 1);
    localparam int SW = $clog2(POST_RST_WAIT + 1);
    localparam int DW = $clog2(DLY_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(RST_TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(POST_RST_WAIT - 1);
    localparam logic [DW-1:0] DLY_LAST    = DW'(DLY_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RST_REQ  = 3'd1,
        ST_RST_WAIT = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_FETCH    = 3'd4,
        ST_SEND     = 3'd5,
        ST_DELAY    = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        K_CMD = 2'd0,
        K_DAT = 2'd1,
        K_DLY = 2'd2,
        K_END = 2'd3
    } kind_t;

    // Init table entry: {kind, byte}
    function automatic logic [9:0] table_entry(input logic [2:0] idx);
        logic [9:0] e;
        case (idx)
            3'd0:    e = {K_CMD, 8'h11};
            3'd1:    e = {K_DLY, 8'h00};
            3'd2:    e = {K_CMD, 8'h3A};
            3'd3:    e = {K_DAT, 8'h55};
            3'd4:    e = {K_CMD, 8'h36};
            3'd5:    e = {K_DAT, 8'h48};
            3'd6:    e = {K_CMD, 8'h29};
            default: e = {K_END, 8'h00};
        endcase
        return e;
    endfunction

    state_t          state_r;
    logic [2:0]      idx_r;
    logic [TW-1:0]   tmo_cnt_r;
    logic [SW-1:0]   settle_cnt_r;
    logic [DW-1:0]   dly_cnt_r;
    logic [9:0]      entry_s;
    kind_t           kind_s;
    logic [7:0]      byte_s;

    // Decode the table entry addressed by the current index
    always_comb begin
        entry_s = table_entry(idx_r);
        kind_s  = kind_t'(entry_s[9:8]);
        byte_s  = entry_s[7:0];
    end

    // Sequencer state, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= 3'd0;
            tmo_cnt_r    <= '0;
            settle_cnt_r <= '0;
            dly_cnt_r    <= '0;
            o_reset_ena  <= 1'b0;
            o_reset_val  <= 1'b1;
            o_spi_valid  <= 1'b0;
            o_spi_data   <= 8'h00;
            o_spi_dc     <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        state_r     <= ST_RST_REQ;
                        idx_r       <= 3'd0;
                        o_error     <= 1'b0;
                        o_done      <= 1'b0;
                        o_busy      <= 1'b1;
                        o_reset_ena <= 1'b1;
                        o_reset_val <= 1'b0;
                    end
                end
                ST_RST_REQ: begin
                    state_r     <= ST_RST_WAIT;
                    o_reset_ena <= 1'b0;
                    tmo_cnt_r   <= '0;
                end
                ST_RST_WAIT: begin
                    // A completion flag on the final count still wins over the timeout
                    if (i_reset_sent) begin
                        state_r      <= ST_SETTLE;
                        settle_cnt_r <= '0;
                        o_reset_val  <= 1'b1;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        state_r     <= ST_IDLE;
                        o_error     <= 1'b1;
                        o_busy      <= 1'b0;
                        o_reset_val <= 1'b1;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        state_r <= ST_FETCH;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + SW'(1);
                    end
                end
                ST_FETCH: begin
                    case (kind_s)
                        K_CMD, K_DAT: begin
                            state_r     <= ST_SEND;
                            o_spi_valid <= 1'b1;
                            o_spi_data  <= byte_s;
                            o_spi_dc    <= (kind_s == K_DAT);
                        end
                        K_DLY: begin
                            state_r   <= ST_DELAY;
                            dly_cnt_r <= '0;
                        end
                        K_END: begin
                            state_r <= ST_DONE;
                            o_done  <= 1'b1;
                            o_busy  <= 1'b0;
                        end
                        default: begin
                            state_r <= ST_DONE;
                            o_done  <= 1'b1;
                            o_busy  <= 1'b0;
                        end
                    endcase
                end
                ST_SEND: begin
                    if (i_spi_ready) begin
                        state_r     <= ST_FETCH;
                        idx_r       <= idx_r + 3'd1;
                        o_spi_valid <= 1'b0;
                        o_spi_data  <= 8'h00;
                        o_spi_dc    <= 1'b0;
                    end
                end
                ST_DELAY: begin
                    if (dly_cnt_r == DLY_LAST) begin
                        state_r <= ST_FETCH;
                        idx_r   <= idx_r + 3'd1;
                    end else begin
                        dly_cnt_r <= dly_cnt_r + DW'(1);
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    o_reset_ena <= 1'b0;
                    o_reset_val <= 1'b1;
                    o_spi_valid <= 1'b0;
                    o_spi_data  <= 8'h00;
                    o_spi_dc    <= 1'b0;
                    o_busy      <= 1'b0;
                    o_done      <= 1'b0;
                end
            endcase
        end
    end
endmodule
